// File: rtl/prince_ctr_keystream.sv
// CTR-mode keystream front-end for a combinational PRINCE core with a 2-entry output buffer.
// Optional build macro PRINCE_CTR_WRAP_ERR_EN rejects requests whose counter range would wrap and flags err_o.
module prince_ctr_keystream #(
    parameter int DataWidth = 64,
    parameter int KeyWidth  = 128,
    parameter int CtrWidth  = 32,
    parameter int LenWidth  = 8,
    parameter int Latency   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef PRINCE_CTR_WRAP_ERR_EN
    output logic                          err_o,
`endif
    input  logic [KeyWidth-1:0]           key_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [DataWidth-CtrWidth-1:0] req_nonce_i,
    input  logic [CtrWidth-1:0]           req_ctr_i,
    input  logic [LenWidth-1:0]           req_len_i,
    output logic [DataWidth-1:0]          prince_data_o,
    output logic [KeyWidth-1:0]           prince_key_o,
    output logic                          prince_dec_o,
    input  logic [DataWidth-1:0]          prince_data_i,
    output logic                          ks_valid_o,
    input  logic                          ks_ready_i,
    output logic [DataWidth-1:0]          ks_data_o,
    output logic                          ks_last_o,
    output logic                          busy_o
);

    localparam int NonceWidth = DataWidth - CtrWidth;
    localparam int WaitWidth  = $clog2(Latency + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [NonceWidth-1:0]   nonce_q;
    logic [CtrWidth-1:0]     ctr_q;
    logic [LenWidth-1:0]     rem_q;
    logic [KeyWidth-1:0]     key_q;
    logic [WaitWidth-1:0]    wait_q;

    logic [DataWidth-1:0]    fifo_data_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              cnt_q;

    logic accept, start, wrap_bad, sample, slot_free, push, pop;

`ifdef PRINCE_CTR_WRAP_ERR_EN
    logic err_q;

    function automatic logic ctr_wraps(input logic [CtrWidth-1:0] ctr,
                                       input logic [LenWidth-1:0] len);
        logic [CtrWidth+LenWidth:0] last_ctr;
        last_ctr = {{(LenWidth+1){1'b0}}, ctr} + {{(CtrWidth+1){1'b0}}, len}
                   - (CtrWidth+LenWidth+1)'(1);
        return last_ctr[CtrWidth+LenWidth:CtrWidth] != '0;
    endfunction

    assign wrap_bad = ctr_wraps(req_ctr_i, req_len_i);
    assign err_o    = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept && req_len_i != '0 && wrap_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign wrap_bad = 1'b0;
`endif

    assign accept    = (state_q == IDLE) && req_valid_i;
    assign start     = accept && (req_len_i != '0) && !wrap_bad;
    assign pop       = (cnt_q != 2'd0) && ks_ready_i;
    // A full buffer still accepts a push when its head leaves on the same edge.
    assign slot_free = (cnt_q != 2'd2) || pop;
    assign sample    = ((state_q == RUN) && (wait_q == WaitWidth'(1))) || (state_q == HOLD);
    assign push      = sample && slot_free;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN, HOLD: begin
                if (push && rem_q == LenWidth'(1)) state_d = IDLE;
                else if (push)                      state_d = RUN;
                else if (sample)                    state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Counter block and key held steady for the cipher between updates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nonce_q <= '0;
            ctr_q   <= '0;
            rem_q   <= '0;
            key_q   <= '0;
            wait_q  <= '0;
        end else if (start) begin
            nonce_q <= req_nonce_i;
            ctr_q   <= req_ctr_i;
            rem_q   <= req_len_i;
            key_q   <= key_i;
            wait_q  <= WaitWidth'(Latency);
        end else if (push) begin
            ctr_q   <= ctr_q + CtrWidth'(1);
            rem_q   <= rem_q - LenWidth'(1);
            wait_q  <= WaitWidth'(Latency);
        end else if (state_q == RUN && wait_q != WaitWidth'(1)) begin
            wait_q  <= wait_q - WaitWidth'(1);
        end
    end

    // Keystream buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            cnt_q          <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= prince_data_i;
                fifo_last_q[wr_ptr_q] <= (rem_q == LenWidth'(1));
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign prince_data_o = {nonce_q, ctr_q};
    assign prince_key_o  = key_q;
    assign prince_dec_o  = 1'b0;
    assign ks_valid_o    = (cnt_q != 2'd0);
    assign ks_data_o     = fifo_data_q[rd_ptr_q];
    assign ks_last_o     = fifo_last_q[rd_ptr_q];

endmodule

// File: doc/prince_ctr_keystream.md
Name: prince_ctr_keystream

Overview:
- Sequential CTR-mode front-end for the combinational PRINCE core. Sits directly upstream of the cipher and also consumes its output.
- Forms counter blocks {nonce, counter} and drives the cipher's data, key and decrypt inputs.
- Waits a fixed multicycle latency, then captures each cipher result into a 2-entry keystream buffer with a valid/ready output.
- Used by memory/bus scramblers that XOR the keystream with payload data.

Parameters:
- DataWidth, 64, cipher block width (64 or 32).
- KeyWidth, 128, cipher key width (2*DataWidth).
- CtrWidth, 32, counter field width; low bits of each block, must be < DataWidth.
- LenWidth, 8, width of the block-count field of a request.
- Latency, 2, cycles allowed for the combinational cipher path before sampling; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- key_i  in  KeyWidth  key, sampled on request accept.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_nonce_i  in  DataWidth-CtrWidth  nonce, upper block bits.
- req_ctr_i  in  CtrWidth  starting counter.
- req_len_i  in  LenWidth  number of blocks to generate.
- prince_data_o  out  DataWidth  to cipher data input, registered {nonce_q, ctr_q}.
- prince_key_o  out  KeyWidth  to cipher key input, registered.
- prince_dec_o  out  1  to cipher decrypt select; constant 0.
- prince_data_i  in  DataWidth  from cipher data output.
- ks_valid_o  out  1  keystream block valid.
- ks_ready_i  in  1  keystream consumer ready.
- ks_data_o  out  DataWidth  keystream block.
- ks_last_o  out  1  final block of the current request.
- busy_o  out  1  request in progress (state != IDLE).
- err_o  out  1  only with the optional feature; sticky wrap error.

Behaviour:
- Reset values: all registers and outputs 0; FSM in IDLE; buffer empty. req_ready_o is 1 once reset deasserts.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i with req_len_i != 0: capture nonce, ctr, len, key; load wait counter with Latency; go to RUN.
  - On req_valid_i with req_len_i == 0: accept, stay in IDLE, produce no output.
- RUN and HOLD: req_ready_o = 0. Requests are not queued.
- prince_data_o and prince_key_o update on the accept edge T0 and on each counter advance.
- RUN:
  - Wait counter decrements each cycle.
  - The cycle it reads 1 (sample point, Latency cycles after the last update), if a buffer slot is free: push {prince_data_i, last = (remaining == 1)}.
  - On push: ctr_q <= ctr_q + 1 (modulo 2^CtrWidth); remaining - 1; reload wait counter.
  - If remaining becomes 0, go to IDLE.
  - If no slot is free at the sample point, go to HOLD.
- HOLD: counter frozen, inputs to the cipher stable. Push as soon as a slot frees, then continue as in RUN.
- Timing: first block is visible on ks_valid_o after edge T0 + Latency. Sustained rate is one block per Latency cycles with ks_ready_i high.
- Buffer:
  - 2-entry FIFO; ks_valid_o = not empty; head drives ks_data_o and ks_last_o.
  - Pop on ks_valid_o & ks_ready_i.
  - A slot counts as free if count < 2, or if count == 2 and a pop occurs the same cycle (simultaneous push/pop when full is legal).
  - Ordering is strict FIFO. ks_data_o is held stable while ks_valid_o & !ks_ready_i.
- key_i changes during RUN/HOLD are ignored until the next accept.
- Reset mid-operation: FSM returns to IDLE, buffer flushed, pending blocks discarded, no partial output.
- busy_o deasserts on the edge where the last block is pushed. Buffered blocks may still be draining.

Optional Feature:
- Macro PRINCE_CTR_WRAP_ERR_EN.
- Defined:
  - On accept, if req_ctr_i + req_len_i - 1 exceeds 2^CtrWidth - 1, the request is consumed with no output and err_o is set.
  - err_o stays set until reset. Later requests still operate normally.
- Not defined: no err_o port; the counter wraps silently modulo 2^CtrWidth.

Test Plan:
- Single block: key=0, nonce=0, ctr=0, len=1, Latency=2 -> one ks beat with ks_last_o=1 at T0+2, equal to the PRINCE golden model encryption of 64'h0 under key 0. prince_dec_o=0 throughout.
- Burst: ctr=32'h10, len=4, ks_ready_i=1 -> 4 beats spaced 2 cycles apart. prince_data_o counter field steps 0x10..0x13; last only on beat 4; busy_o low after the 4th push.
- Backpressure: len=5, ks_ready_i=0 for 20 cycles -> 2 beats buffered, FSM in HOLD, prince_data_o stable. Releasing ready delivers all 5 in order, none lost or duplicated.
- Wrap: ctr=32'hFFFF_FFFF, len=2 -> without the macro, blocks use counters FFFFFFFF then 00000000. With PRINCE_CTR_WRAP_ERR_EN, no beats and err_o=1.
- Reset mid-burst: assert rst_i during beat 2 of len=8 -> ks_valid_o=0, busy_o=0, req_ready_o=1 after deassert. A new len=1 request produces a correct single block.
- len=0 plus key change during RUN: len=0 request yields no beats. Changing key_i mid-burst does not alter the remaining blocks.
